// File: rtl/pmem_responder_pkg.sv
// Shared types and sizing for the Wishbone-to-physical-memory line responder.
package pmem_responder_pkg;

    localparam int LINE_WIDTH = 128;
    localparam int BEAT_WIDTH = 32;
    localparam int BEATS      = 4;
    localparam int SEL_WIDTH  = LINE_WIDTH / 8;
    localparam int ADDR_WIDTH = 12;
    localparam int BEAT_IDX_W = 2;

    // Responder FSM states; exposed on the debug port of the top level.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/line_merge_buffer.sv
// 128-bit line buffer: whole-line load, per-beat load and byte-enable merge.
// All three can apply on one edge, in that order, so the last read beat and
// the write-data merge land together.
module line_merge_buffer
    import pmem_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_line,
    input  logic [LINE_WIDTH-1:0] line_data,
    input  logic                  load_beat,
    input  logic [BEAT_IDX_W-1:0] beat_idx,
    input  logic [BEAT_WIDTH-1:0] beat_data,
    input  logic                  merge_en,
    input  logic [SEL_WIDTH-1:0]  merge_sel,
    input  logic [LINE_WIDTH-1:0] merge_data,
    output logic [LINE_WIDTH-1:0] line,
    output logic [BEAT_WIDTH-1:0] beat_out
);

    logic [LINE_WIDTH-1:0] line_q;
    logic [LINE_WIDTH-1:0] line_d;

    // Next buffer value: line load, then beat slot, then selected bytes.
    always_comb begin
        line_d = line_q;
        if (load_line) begin
            line_d = line_data;
        end
        if (load_beat) begin
            line_d[beat_idx*BEAT_WIDTH +: BEAT_WIDTH] = beat_data;
        end
        if (merge_en) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (merge_sel[i]) begin
                    line_d[i*8 +: 8] = merge_data[i*8 +: 8];
                end
            end
        end
    end

    // Buffer register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line     = line_q;
    assign beat_out = line_q[beat_idx*BEAT_WIDTH +: BEAT_WIDTH];

endmodule

// File: rtl/wishbone_pmem_responder.sv
// Wishbone line slave that moves 128-bit lines to/from a 32-bit burst memory.
// Handshake: a request is accepted when wb_CYC & wb_STB are high in IDLE;
// wb_ACK is a single-cycle pulse; pmem_resp marks one beat accepted/valid
// in the cycle it is high and is only honoured in READ/WRITE.
// Partial writes (any SEL other than all-ones) read the line, merge, write back.
module wishbone_pmem_responder
    import pmem_responder_pkg::*;
#(
    parameter int BEATS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_CYC,
    input  logic                  wb_STB,
    input  logic                  wb_WE,
    input  logic [ADDR_WIDTH-1:0] wb_ADR,
    input  logic [SEL_WIDTH-1:0]  wb_SEL,
    input  logic [LINE_WIDTH-1:0] wb_DAT_M,
    output logic [LINE_WIDTH-1:0] wb_DAT_S,
    output logic                  wb_ACK,
    output logic                  wb_RTY,
    output logic [15:0]           pmem_address,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [BEAT_WIDTH-1:0] pmem_wdata,
    input  logic [BEAT_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output state_t                dbg_state
);

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

    state_t                state_q, state_d;
    logic [BEAT_IDX_W-1:0] beat_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic                  we_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic [LINE_WIDTH-1:0] dat_m_q;
    logic                  drop_q;

    logic req_live, accept, full_write, load_beat, merge_en, dropped, busy;

    assign req_live   = wb_CYC & wb_STB;
    assign full_write = wb_WE & (wb_SEL == '1);
    assign busy       = (state_q == READ) || (state_q == WRITE);
    // A master that walked away at any point in the burst gets no ACK.
    assign dropped    = drop_q | ~req_live;

    // Next-state and buffer control.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        load_beat = 1'b0;
        merge_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_live) begin
                    accept  = 1'b1;
                    state_d = full_write ? WRITE : READ;
                end
            end
            READ: begin
                if (pmem_resp) begin
                    load_beat = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        if (we_q) begin
                            merge_en = 1'b1;
                            state_d  = WRITE;
                        end else begin
                            state_d = dropped ? IDLE : ACK;
                        end
                    end
                end
            end
            WRITE: begin
                if (pmem_resp && (beat_q == LAST_BEAT)) begin
                    state_d = dropped ? IDLE : ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, beat counter, latched request and abandon flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_m_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                adr_q   <= wb_ADR;
                we_q    <= wb_WE;
                sel_q   <= wb_SEL;
                dat_m_q <= wb_DAT_M;
                beat_q  <= '0;
                drop_q  <= 1'b0;
            end else begin
                if (busy && pmem_resp) begin
                    beat_q <= beat_q + 1'b1;
                end
                if (busy && !req_live) begin
                    drop_q <= 1'b1;
                end
            end
        end
    end

    line_merge_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .load_line  (accept & full_write),
        .line_data  (wb_DAT_M),
        .load_beat  (load_beat),
        .beat_idx   (beat_q),
        .beat_data  (pmem_rdata),
        .merge_en   (merge_en),
        .merge_sel  (sel_q),
        .merge_data (dat_m_q),
        .line       (wb_DAT_S),
        .beat_out   (pmem_wdata)
    );

    assign pmem_read    = (state_q == READ);
    assign pmem_write   = (state_q == WRITE);
    assign wb_ACK       = (state_q == ACK);
    assign wb_RTY       = 1'b0;
    assign pmem_address = {adr_q, 4'b0000};
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_wishbone_pmem_responder.sv
// Bench for the Wishbone line responder: behavioural burst memory plus a
// line-level reference model of reads, full writes and merged partial writes.
module tb_wishbone_pmem_responder;

    logic          clk;
    logic          rst;
    logic          wb_CYC, wb_STB, wb_WE;
    logic [11:0]   wb_ADR;
    logic [15:0]   wb_SEL;
    logic [127:0]  wb_DAT_M, wb_DAT_S;
    logic          wb_ACK, wb_RTY;
    logic [15:0]   pmem_address;
    logic          pmem_read, pmem_write;
    logic [31:0]   pmem_wdata, pmem_rdata;
    logic          pmem_resp;
    pmem_responder_pkg::state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory device state
    logic [127:0] mem [4096];
    int           mem_wait;
    logic         force_resp;
    int           rd_resps, wr_resps, rd_cycles, wr_cycles, both_high;
    logic [15:0]  last_addr;
    logic [31:0]  wr_log[$];
    logic [31:0]  exp_q[$];

    wishbone_pmem_responder #(.BEATS(4)) dut (
        .clk(clk), .rst(rst),
        .wb_CYC(wb_CYC), .wb_STB(wb_STB), .wb_WE(wb_WE), .wb_ADR(wb_ADR),
        .wb_SEL(wb_SEL), .wb_DAT_M(wb_DAT_M), .wb_DAT_S(wb_DAT_S),
        .wb_ACK(wb_ACK), .wb_RTY(wb_RTY),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Burst memory: mem_wait idle cycles before each beat's resp.
    initial begin
        logic [1:0] rd_beat, wr_beat;
        int         wait_cnt;
        logic [11:0] a;
        rd_beat = 0; wr_beat = 0; wait_cnt = 0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (pmem_read && pmem_write) both_high++;
            if (pmem_read)  rd_cycles++;
            if (pmem_write) wr_cycles++;
            if (!pmem_read)  rd_beat = 0;
            if (!pmem_write) wr_beat = 0;
            if (pmem_read || pmem_write) begin
                if (wait_cnt == mem_wait) begin
                    wait_cnt  = 0;
                    pmem_resp = 1'b1;
                    a = pmem_address[15:4];
                    last_addr = pmem_address;
                    if (pmem_read) begin
                        pmem_rdata = mem[a][rd_beat*32 +: 32];
                        rd_beat++;
                        rd_resps++;
                    end else begin
                        wr_log.push_back(pmem_wdata);
                        mem[a][wr_beat*32 +: 32] = pmem_wdata;
                        wr_beat++;
                        wr_resps++;
                    end
                end else begin
                    pmem_resp = 1'b0;
                    pmem_rdata = $urandom();
                    wait_cnt++;
                end
            end else begin
                wait_cnt  = 0;
                pmem_resp = force_resp;
                pmem_rdata = $urandom();
            end
        end
    end

    function automatic logic [127:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference model: bytes with SEL set come from the write data.
    function automatic logic [127:0] merge_line(input logic [127:0] old, input logic [127:0] dat,
                                                input logic [15:0] sel);
        logic [127:0] mask;
        mask = '0;
        for (int i = 0; i < 16; i++) if (sel[i]) mask[i*8 +: 8] = 8'hFF;
        return (old & ~mask) | (dat & mask);
    endfunction

    // Predict a transaction and clear the memory activity logs.
    task automatic model_txn(input logic we, input logic [11:0] adr, input logic [15:0] sel,
                             input logic [127:0] dat, output logic [127:0] exp_line,
                             output int exp_lat, output int exp_reads);
        logic full;
        full      = we && (sel == 16'hFFFF);
        exp_line  = we ? merge_line(mem[adr], dat, sel) : mem[adr];
        exp_reads = full ? 0 : 4;
        exp_lat   = 1 + ((we && !full) ? 8 : 4) * (mem_wait + 1);
        exp_q.delete();
        if (we) for (int k = 0; k < 4; k++) exp_q.push_back(exp_line[k*32 +: 32]);
        wr_log.delete();
        rd_resps = 0; wr_resps = 0; rd_cycles = 0; wr_cycles = 0;
    endtask

    // driver tasks
    task automatic run_txn(input logic we, input logic [11:0] adr, input logic [15:0] sel,
                           input logic [127:0] dat, input int drop_after,
                           output logic got_ack, output logic [127:0] dat_s, output int cycles);
        got_ack = 1'b0; dat_s = '0; cycles = 0;
        wb_CYC = 1'b1; wb_STB = 1'b1; wb_WE = we; wb_ADR = adr; wb_SEL = sel; wb_DAT_M = dat;
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (wb_ACK === 1'b1) begin
                got_ack = 1'b1;
                dat_s   = wb_DAT_S;
                break;
            end
            if (drop_after >= 0 && cycles == drop_after) begin
                wb_CYC = 1'b0; wb_STB = 1'b0;
            end
            if (drop_after >= 0 && cycles >= 40) break;
        end
    endtask

    task automatic bus_release();
        wb_CYC = 1'b0; wb_STB = 1'b0; wb_WE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_release();
        repeat (3) @(negedge clk);
        n_checks++; if (wb_ACK !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", wb_ACK); end
        n_checks++; if (wb_RTY !== 1'b0) begin n_fail++; $display("FAIL reset_rty: got %b expected 0", wb_RTY); end
        n_checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b%b expected 00", pmem_read, pmem_write); end
        n_checks++; if (pmem_address !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0000", pmem_address); end
        n_checks++; if (wb_DAT_S !== 128'h0) begin n_fail++; $display("FAIL reset_dat_s: got %h expected 0", wb_DAT_S); end
        n_checks++; if (dbg_state !== pmem_responder_pkg::IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_directed_read();
        logic [127:0] el, ds; int lat, rds, cyc; logic ack;
        mem_wait = 0;
        mem[12'h0A3] = 128'h44444444_33333333_22222222_11111111;
        model_txn(1'b0, 12'h0A3, 16'h0, 128'h0, el, lat, rds);
        run_txn(1'b0, 12'h0A3, 16'h0, 128'h0, -1, ack, ds, cyc);
        bus_release(); idle(1);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL read_ack: got %b expected 1", ack); end
        n_checks++; if (ds !== 128'h44444444_33333333_22222222_11111111) begin n_fail++; $display("FAIL read_data: got %h expected 44444444333333332222222211111111", ds); end
        n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL read_latency: got %0d expected 5", cyc); end
        n_checks++; if (last_addr !== 16'h0A30) begin n_fail++; $display("FAIL read_addr: got %h expected 0a30", last_addr); end
        n_checks++; if (rd_resps !== 4 || wr_resps !== 0) begin n_fail++; $display("FAIL read_beats: got rd %0d wr %0d expected rd 4 wr 0", rd_resps, wr_resps); end
    endtask

    task automatic test_full_write();
        logic [127:0] el, ds, dat; int lat, rds, cyc; logic ack;
        dat = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
        mem_wait = 0;
        mem[12'h155] = rand_line();
        model_txn(1'b1, 12'h155, 16'hFFFF, dat, el, lat, rds);
        run_txn(1'b1, 12'h155, 16'hFFFF, dat, -1, ack, ds, cyc);
        bus_release(); idle(1);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL fullwr_ack: got %b expected 1", ack); end
        n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL fullwr_latency: got %0d expected 5", cyc); end
        n_checks++; if (rd_cycles !== 0) begin n_fail++; $display("FAIL fullwr_no_read: got %0d read cycles expected 0", rd_cycles); end
        n_checks++; if (wr_log.size() !== 4) begin n_fail++; $display("FAIL fullwr_beats: got %0d expected 4", wr_log.size()); end
        n_checks++; if (wr_log.size() > 0 && wr_log[0] !== 32'h12345678) begin n_fail++; $display("FAIL fullwr_first_beat: got %h expected 12345678", wr_log[0]); end
        for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
            n_checks++; if (wr_log[k] !== exp_q[k]) begin n_fail++; $display("FAIL fullwr_beat%0d: got %h expected %h", k, wr_log[k], exp_q[k]); end
        end
        n_checks++; if (ds !== dat) begin n_fail++; $display("FAIL fullwr_dat_s: got %h expected %h", ds, dat); end
    endtask

    task automatic test_partial_write();
        logic [127:0] el, ds, dat; int lat, rds, cyc; logic ack;
        logic [31:0] want [4];
        want[0] = 32'hAABBCCDD; want[1] = 32'h55555555; want[2] = 32'h55555555; want[3] = 32'h55555555;
        dat = {$urandom(), $urandom(), $urandom(), 32'hAABBCCDD};
        mem_wait = 0;
        mem[12'h2C7] = {16{8'h55}};
        model_txn(1'b1, 12'h2C7, 16'h000F, dat, el, lat, rds);
        run_txn(1'b1, 12'h2C7, 16'h000F, dat, -1, ack, ds, cyc);
        bus_release(); idle(1);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL partwr_ack: got %b expected 1", ack); end
        n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL partwr_latency: got %0d expected 9", cyc); end
        n_checks++; if (rd_resps !== 4) begin n_fail++; $display("FAIL partwr_reads: got %0d expected 4", rd_resps); end
        n_checks++; if (wr_log.size() !== 4) begin n_fail++; $display("FAIL partwr_beats: got %0d expected 4", wr_log.size()); end
        for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
            n_checks++; if (wr_log[k] !== want[k]) begin n_fail++; $display("FAIL partwr_beat%0d: got %h expected %h", k, wr_log[k], want[k]); end
        end
        n_checks++; if (ds !== 128'h55555555_55555555_55555555_AABBCCDD) begin n_fail++; $display("FAIL partwr_dat_s: got %h expected 555555555555555555555555aabbccdd", ds); end
    endtask

    task automatic test_wait_states();
        logic [127:0] el, ds; int lat, rds, cyc; logic ack;
        mem_wait = 2;
        mem[12'h3E1] = rand_line();
        model_txn(1'b0, 12'h3E1, 16'h0, 128'h0, el, lat, rds);
        run_txn(1'b0, 12'h3E1, 16'h0, 128'h0, -1, ack, ds, cyc);
        bus_release(); idle(1);
        mem_wait = 0;
        n_checks++; if (cyc !== 13) begin n_fail++; $display("FAIL wait_latency: got %0d expected 13", cyc); end
        n_checks++; if (rd_cycles !== 12) begin n_fail++; $display("FAIL wait_read_held: got %0d read cycles expected 12", rd_cycles); end
        n_checks++; if (ack !== 1'b1 || ds !== el) begin n_fail++; $display("FAIL wait_data: got ack %b %h expected 1 %h", ack, ds, el); end
    endtask

    task automatic test_drop();
        logic [127:0] el, ds; int lat, rds, cyc; logic ack;
        mem_wait = 0;
        mem[12'h044] = rand_line();
        model_txn(1'b0, 12'h044, 16'h0, 128'h0, el, lat, rds);
        run_txn(1'b0, 12'h044, 16'h0, 128'h0, 2, ack, ds, cyc);
        bus_release();
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL drop_no_ack: got %b expected 0", ack); end
        n_checks++; if (rd_resps !== 4) begin n_fail++; $display("FAIL drop_burst_done: got %0d beats expected 4", rd_resps); end
        n_checks++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got pmem_read %b expected 0", pmem_read); end
        mem[12'h045] = rand_line();
        model_txn(1'b0, 12'h045, 16'h0, 128'h0, el, lat, rds);
        run_txn(1'b0, 12'h045, 16'h0, 128'h0, -1, ack, ds, cyc);
        bus_release(); idle(1);
        n_checks++; if (ack !== 1'b1 || cyc !== 5 || ds !== el) begin n_fail++; $display("FAIL drop_next: got ack %b lat %0d %h expected 1 5 %h", ack, cyc, ds, el); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] el, ds, dat; int lat, rds, cyc; logic ack, ack_seen;
        mem_wait = 0; ack_seen = 1'b0;
        dat = rand_line();
        model_txn(1'b1, 12'h0F0, 16'hFFFF, dat, el, lat, rds);
        wb_CYC = 1'b1; wb_STB = 1'b1; wb_WE = 1'b1; wb_ADR = 12'h0F0; wb_SEL = 16'hFFFF; wb_DAT_M = dat;
        repeat (3) begin @(negedge clk); if (wb_ACK === 1'b1) ack_seen = 1'b1; end
        n_checks++; if (pmem_write !== 1'b1 || wr_resps !== 3) begin n_fail++; $display("FAIL rstmid_in_burst: got write %b beats %0d expected 1 3", pmem_write, wr_resps); end
        rst = 1'b1;
        bus_release();
        @(negedge clk);
        if (wb_ACK === 1'b1) ack_seen = 1'b1;
        n_checks++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0) begin n_fail++; $display("FAIL rstmid_rw: got %b%b expected 00", pmem_read, pmem_write); end
        n_checks++; if (ack_seen !== 1'b0 || wb_RTY !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack: got ack %b rty %b expected 0 0", ack_seen, wb_RTY); end
        n_checks++; if (pmem_address !== 16'h0 || wb_DAT_S !== 128'h0 || pmem_wdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_outputs: got addr %h dat %h wdata %h expected all 0", pmem_address, wb_DAT_S, pmem_wdata); end
        rst = 1'b0;
        idle(1);
        mem[12'h0F1] = rand_line();
        model_txn(1'b0, 12'h0F1, 16'h0, 128'h0, el, lat, rds);
        run_txn(1'b0, 12'h0F1, 16'h0, 128'h0, -1, ack, ds, cyc);
        bus_release(); idle(1);
        n_checks++; if (ack !== 1'b1 || cyc !== 5 || ds !== el) begin n_fail++; $display("FAIL rstmid_next_read: got ack %b lat %0d %h expected 1 5 %h", ack, cyc, ds, el); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] el, ds; int lat, rds, cyc; logic ack;
        mem_wait = 0;
        mem[12'h700] = rand_line();
        mem[12'h701] = rand_line();
        model_txn(1'b0, 12'h700, 16'h0, 128'h0, el, lat, rds);
        run_txn(1'b0, 12'h700, 16'h0, 128'h0, -1, ack, ds, cyc);
        n_checks++; if (ack !== 1'b1 || cyc !== 5 || ds !== el) begin n_fail++; $display("FAIL b2b_first: got ack %b lat %0d %h expected 1 5 %h", ack, cyc, ds, el); end
        // Request held straight through the ACK cycle: one idle edge must pass.
        model_txn(1'b0, 12'h701, 16'h0, 128'h0, el, lat, rds);
        run_txn(1'b0, 12'h701, 16'h0, 128'h0, -1, ack, ds, cyc);
        bus_release(); idle(1);
        n_checks++; if (ack !== 1'b1 || ds !== el) begin n_fail++; $display("FAIL b2b_second_data: got ack %b %h expected 1 %h", ack, ds, el); end
        n_checks++; if (cyc !== lat + 1) begin n_fail++; $display("FAIL b2b_gap: got %0d expected %0d", cyc, lat + 1); end
    endtask

    task automatic test_spurious_resp();
        logic [127:0] el, ds, held; int lat, rds, cyc; logic ack, bad;
        mem_wait = 0; bad = 1'b0;
        mem[12'h812] = rand_line();
        model_txn(1'b0, 12'h812, 16'h0, 128'h0, el, lat, rds);
        run_txn(1'b0, 12'h812, 16'h0, 128'h0, -1, ack, ds, cyc);
        bus_release(); idle(1);
        held = el;
        force_resp = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || wb_ACK !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL spurious_idle: got activity %b expected 0", bad); end
        n_checks++; if (wb_DAT_S !== held) begin n_fail++; $display("FAIL spurious_dat_s: got %h expected %h", wb_DAT_S, held); end
        force_resp = 1'b0;
        mem[12'h813] = rand_line();
        model_txn(1'b0, 12'h813, 16'h0, 128'h0, el, lat, rds);
        run_txn(1'b0, 12'h813, 16'h0, 128'h0, -1, ack, ds, cyc);
        bus_release(); idle(1);
        n_checks++; if (ack !== 1'b1 || cyc !== 5 || ds !== el) begin n_fail++; $display("FAIL spurious_next_read: got ack %b lat %0d %h expected 1 5 %h", ack, cyc, ds, el); end
    endtask

    task automatic test_random();
        logic [127:0] el, ds, dat; int lat, rds, cyc; logic ack, we;
        logic [11:0] adr; logic [15:0] sel;
        for (int i = 0; i < 40; i++) begin
            adr = 12'($urandom_range(0, 4095));
            mem[adr] = rand_line();
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       sel = 16'hFFFF;
                1:       sel = 16'h0000;
                default: sel = 16'($urandom());
            endcase
            if (i == 0) begin we = 1'b1; sel = 16'h0000; end
            dat = rand_line();
            mem_wait = $urandom_range(0, 2);
            model_txn(we, adr, sel, dat, el, lat, rds);
            run_txn(we, adr, sel, dat, -1, ack, ds, cyc);
            bus_release();
            n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rand%0d_ack: got %b expected 1", i, ack); end
            n_checks++; if (ds !== el) begin n_fail++; $display("FAIL rand%0d_dat_s: got %h expected %h", i, ds, el); end
            n_checks++; if (cyc !== lat) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, cyc, lat); end
            n_checks++; if (rd_resps !== rds) begin n_fail++; $display("FAIL rand%0d_reads: got %0d expected %0d", i, rd_resps, rds); end
            n_checks++; if (wr_log.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_write_count: got %0d expected %0d", i, wr_log.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size() && k < wr_log.size(); k++) begin
                n_checks++; if (wr_log[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand%0d_beat%0d: got %h expected %h", i, k, wr_log[k], exp_q[k]); end
            end
            n_checks++; if (mem[adr] !== el) begin n_fail++; $display("FAIL rand%0d_mem: got %h expected %h", i, mem[adr], el); end
            idle($urandom_range(1, 2));
        end
        mem_wait = 0;
    endtask

    initial begin
        rst = 1'b1;
        wb_CYC = 1'b0; wb_STB = 1'b0; wb_WE = 1'b0;
        wb_ADR = '0; wb_SEL = '0; wb_DAT_M = '0;
        force_resp = 1'b0; mem_wait = 0;
        rd_resps = 0; wr_resps = 0; rd_cycles = 0; wr_cycles = 0; both_high = 0;
        last_addr = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;

        test_reset();
        test_directed_read();
        test_full_write();
        test_partial_write();
        test_wait_states();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        test_spurious_resp();
        test_random();

        n_checks++; if (both_high !== 0) begin n_fail++; $display("FAIL read_write_exclusive: got %0d overlapping cycles expected 0", both_high); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wishbone_pmem_responder.md
WISHBONE_PMEM_RESPONDER -- requirements
Module: wishbone_pmem_responder

Interface
REQ-001 SHALL have parameter BEATS, default 4, number of 32-bit physical-memory beats per 128-bit line (fixed at 4; other values unsupported).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port wb_CYC  input  1  wishbone bus cycle.
REQ-005 SHALL have port wb_STB  input  1  wishbone strobe.
REQ-006 SHALL have port wb_WE  input  1  1 = line write, 0 = line read.
REQ-007 SHALL have port wb_ADR  input  12  line address.
REQ-008 SHALL have port wb_SEL  input  16  byte enables for writes, bit i covers DAT_M[8i+7:8i].
REQ-009 SHALL have port wb_DAT_M  input  128  write line.
REQ-010 SHALL have port wb_DAT_S  output  128  read line.
REQ-011 SHALL have port wb_ACK  output  1  transaction complete.
REQ-012 SHALL have port wb_RTY  output  1  retry; constant 0.
REQ-013 SHALL have port pmem_address  output  16  byte address = {latched ADR, 4'b0}.
REQ-014 SHALL have port pmem_read / pmem_write  output  1 each  burst request, level-held.
REQ-015 SHALL have port pmem_wdata  output  32  write beat; pmem_rdata  input  32  read beat.
REQ-016 SHALL have port pmem_resp  input  1  one beat accepted/valid this cycle.

Function
REQ-017 SHALL use FSM states IDLE, READ, WRITE, ACK.
REQ-018 In IDLE with wb_CYC&wb_STB sampled high, SHALL latch ADR, WE, SEL, DAT_M, clear beat counter, and go to WRITE if WE&(SEL==16'hFFFF), else READ.
REQ-019 pmem_read SHALL equal 1 exactly in READ; pmem_write SHALL equal 1 exactly in WRITE; never both.
REQ-020 Beat k (0..3) SHALL map to line bits [32k+31:32k]; beat counter SHALL advance on each pmem_resp and wrap to 0 after beat 3.
REQ-021 In READ, on pmem_resp the beat pmem_rdata SHALL be stored into line buffer slot k.
REQ-022 On 4th READ resp: if latched WE=0 go to ACK; if WE=1 (partial write) merge latched DAT_M bytes where SEL=1 into buffer in the same edge and go to WRITE.
REQ-023 In WRITE, pmem_wdata SHALL present buffer slot k (full write: latched DAT_M slot k); on 4th resp go to ACK.
REQ-024 ACK state SHALL last exactly one cycle with wb_ACK=1 and wb_DAT_S=line buffer; then IDLE.
REQ-025 wb_ACK SHALL be 0 in every other state; wb_DAT_S SHALL hold the buffer value at all times.
REQ-026 Zero-wait memory latency: read ACK 5 cycles after accept edge; full write 5; partial write 9.
REQ-027 WE=1 with SEL=0 SHALL still perform read then write-back of unchanged line.
REQ-028 If wb_CYC or wb_STB drops mid-burst, burst SHALL complete; wb_ACK SHALL be suppressed; return to IDLE.
REQ-029 New request SHALL not be accepted before the cycle after ACK (back-to-back minimum one idle cycle).
REQ-030 pmem_resp outside READ/WRITE SHALL be ignored.

Reset
REQ-031 On rst: state IDLE, beat counter 0, line buffer 0, latched request 0; wb_ACK, wb_RTY, pmem_read, pmem_write 0; pmem_address 0.
REQ-032 rst mid-burst SHALL drop pmem_read/pmem_write the following cycle with no ACK; rst has priority over all other inputs.

Structure
REQ-033 Package pmem_responder_pkg SHALL hold the state enum, LINE_WIDTH=128, BEAT_WIDTH=32, BEATS=4.
REQ-034 Sub-module line_merge_buffer SHALL hold the 128-bit buffer with per-beat load and SEL byte merge.

Verification
REQ-035 Read ADR=12'h0A3, memory beats 11111111,22222222,33333333,44444444 -> pmem_address 16'h0A30, wb_DAT_S=128'h44444444_33333333_22222222_11111111 with ACK 5 cycles after accept.
REQ-036 Full write SEL=16'hFFFF, DAT_M=128'hDEADBEEF_... -> no pmem_read, 4 write beats low word first, ACK after 4th resp.
REQ-037 Partial write SEL=16'h000F, DAT_M low word AABBCCDD over memory line of all 0x55 -> write-back beats AABBCCDD,55555555,55555555,55555555.
REQ-038 Memory with 2 wait cycles per beat -> pmem_read held continuously, ACK 13 cycles after accept.
REQ-039 wb_STB dropped after beat 1 -> burst completes, wb_ACK never asserts, next request accepted normally.
REQ-040 rst asserted during beat 2 of write -> pmem_write 0 next cycle, all outputs at reset values, subsequent read correct.
